// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT front-end framer.
package fft_pkg;
  localparam int FFT_LEN    = 65536;
  localparam int FFT_DATA_W = 16;
  localparam int CNT_W      = $clog2(FFT_LEN);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} framer_state_t;
endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry registered skid buffer; read side is driven straight from the head register.
// Exposes next-cycle room/empty so the owner can register its own ready and drain decisions.
module fft_skid_buf #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_data,
  output logic         room_next,
  output logic         empty_next,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [W-1:0] rd_data
);

  logic [1:0]   cnt;
  logic [1:0]   cnt_nxt;
  logic [W-1:0] head_q;
  logic [W-1:0] skid_q;
  logic         push;
  logic         pop;

  // The writer only pushes while it holds a registered ready derived from room_next.
  assign push = wr_valid;
  assign pop  = rd_ready && (cnt != 2'd0);

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + 2'd1;
    else if (pop && !push)
      cnt_nxt = cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (pop && cnt == 2'd2)
        head_q <= skid_q;
      else if (push && (cnt == 2'd0 || (pop && cnt == 2'd1)))
        head_q <= wr_data;
      if (push && ((cnt == 2'd1 && !pop) || (cnt == 2'd2 && pop)))
        skid_q <= wr_data;
    end
  end

  assign rd_valid   = (cnt != 2'd0);
  assign rd_data    = head_q;
  assign room_next  = (cnt_nxt != 2'd2);
  assign empty_next = (cnt_nxt == 2'd0);

endmodule

// File: rtl/fft_sink_framer.sv
// Frames a free-running sample stream into FFT_LEN-sample Avalon-ST blocks with sop/eop,
// running a programmed number of frames (or until stopped) and never emitting a partial frame.
module fft_sink_framer #(
  parameter int FFT_LEN = fft_pkg::FFT_LEN,
  parameter int DATA_W  = fft_pkg::FFT_DATA_W,
  parameter int CNT_W   = $clog2(FFT_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       num_frames,
  input  logic              inverse_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sink_valid,
  input  logic              sink_ready,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic [1:0]        sink_error,
  output logic              inverse,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frames_done
);
  import fft_pkg::*;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_LEN - 1);

  framer_state_t     state;
  framer_state_t     state_nxt;
  logic [CNT_W-1:0]  in_idx;
  logic [15:0]       frames_acc;
  logic [15:0]       nf_q;
  logic              stop_pend;
  logic              accept;
  logic              tag_sop;
  logic              tag_eop;
  logic              last_frame;
  logic              buf_room_nxt;
  logic              buf_empty_nxt;
  logic [DATA_W+1:0] buf_out;

  assign accept  = in_valid && in_ready;
  assign tag_sop = (in_idx == '0);
  assign tag_eop = (in_idx == LAST_IDX);

  // A stop arriving alongside the eop accept still ends the run on that frame.
  assign last_frame = stop_pend || stop ||
                      ((nf_q != 16'd0) && (16'(frames_acc + 16'd1) == nf_q));

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (accept && tag_eop && last_frame) state_nxt = DRAIN;
      DRAIN:   if (buf_empty_nxt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready    <= 1'b0;
      in_idx      <= '0;
      frames_acc  <= 16'd0;
      nf_q        <= 16'd0;
      stop_pend   <= 1'b0;
      inverse     <= 1'b0;
      frames_done <= 16'd0;
    end else begin
      // Registered ready: looks ahead at both the FSM and the buffer occupancy.
      in_ready <= (state_nxt == STREAM) && buf_room_nxt;

      if (state == IDLE && start) begin
        nf_q       <= num_frames;
        inverse    <= inverse_in;
        in_idx     <= '0;
        frames_acc <= 16'd0;
        stop_pend  <= 1'b0;
      end else if (state == STREAM) begin
        if (stop)
          stop_pend <= 1'b1;
        if (accept) begin
          in_idx <= in_idx + CNT_W'(1);
          if (tag_eop)
            frames_acc <= frames_acc + 16'd1;
        end
      end

      if (state == IDLE && start)
        frames_done <= 16'd0;
      else if (sink_valid && sink_ready && sink_eop)
        frames_done <= frames_done + 16'd1;
    end
  end

  fft_skid_buf #(
    .W (DATA_W + 2)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (accept),
    .wr_data    ({tag_sop, tag_eop, in_data}),
    .room_next  (buf_room_nxt),
    .empty_next (buf_empty_nxt),
    .rd_valid   (sink_valid),
    .rd_ready   (sink_ready),
    .rd_data    (buf_out)
  );

  assign sink_sop   = buf_out[DATA_W+1];
  assign sink_eop   = buf_out[DATA_W];
  assign sink_real  = buf_out[DATA_W-1:0];
  assign sink_imag  = '0;
  assign sink_error = 2'b00;

endmodule

// File: tb/tb_fft_sink_framer.sv
// Directed bench for fft_sink_framer with FFT_LEN=16: framing, backpressure, stop, gaps, reset.
module tb_fft_sink_framer;
  localparam int L = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] num_frames = 16'd0;
  logic        inverse_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic        sink_valid;
  logic        sink_ready = 1'b1;
  logic        sink_sop;
  logic        sink_eop;
  logic [15:0] sink_real;
  logic [15:0] sink_imag;
  logic [1:0]  sink_error;
  logic        inverse;
  logic        busy;
  logic        done;
  logic [15:0] frames_done;

  fft_sink_framer #(.FFT_LEN(L)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .num_frames  (num_frames),
    .inverse_in  (inverse_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .sink_valid  (sink_valid),
    .sink_ready  (sink_ready),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .sink_real   (sink_real),
    .sink_imag   (sink_imag),
    .sink_error  (sink_error),
    .inverse     (inverse),
    .busy        (busy),
    .done        (done),
    .frames_done (frames_done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_xfer_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          stall_viol = 0;
  bit          rdy_toggle = 1'b0;
  logic        stalled = 1'b0;
  logic [17:0] stall_val = '0;
  logic [17:0] mon_q[$];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    sink_ready = rdy_toggle ? ~sink_ready : 1'b1;
  end

  // Output monitor: logs every transfer and watches that stalled outputs hold still.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled && (!sink_valid || {sink_sop, sink_eop, sink_real} !== stall_val))
        stall_viol++;
      stalled   = sink_valid && !sink_ready;
      stall_val = {sink_sop, sink_eop, sink_real};
      if (sink_valid && sink_ready) begin
        mon_q.push_back({sink_sop, sink_eop, sink_real});
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] exp_w(input int i, input int base);
    logic sop;
    logic eop;
    sop = ((i % L) == 0);
    eop = ((i % L) == L - 1);
    return {sop, eop, 16'(base + i)};
  endfunction

  task automatic clear_mon();
    mon_q.delete();
    done_cnt   = 0;
    stall_viol = 0;
  endtask

  task automatic do_start(input logic [15:0] nf, input logic inv, input logic with_stop);
    num_frames = nf;
    inverse_in = inv;
    start      = 1'b1;
    stop       = with_stop;
    step();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Presents base+k until n samples are accepted or the cycle budget runs out.
  task automatic feed(input int n, input int base, input int gap_at, input int gap_len,
                      input int stop_at, input int start_at, output int acc);
    int k;
    int gap;
    int budget;
    k = 0;
    gap = 0;
    budget = 0;
    while (k < n && budget < 200) begin
      in_valid = 1'b1;
      in_data  = 16'(base + k);
      if (k == gap_at && gap < gap_len) begin
        in_valid = 1'b0;
        gap++;
      end
      stop  = (k == stop_at) && in_valid;
      start = (k == start_at) && in_valid;
      if (in_valid && in_ready)
        k++;
      step();
      budget++;
    end
    in_valid = 1'b0;
    stop     = 1'b0;
    start    = 1'b0;
    acc      = k;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int acc;
    bit ok;

    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bit ok;

    // Reset state
    repeat (3) step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sink_valid", sink_valid, 0);
    chk("rst_sop_eop", {sink_sop, sink_eop}, 0);
    chk("rst_real", sink_real, 0);
    chk("rst_imag", sink_imag, 0);
    chk("rst_error", sink_error, 0);
    chk("rst_inverse", inverse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frames_done", frames_done, 0);
    rst_n = 1'b1;
    step();

    // Two frames, sink always ready
    clear_mon();
    do_start(16'd2, 1'b1, 1'b0);
    chk("t1_busy", busy, 1);
    chk("t1_inverse", inverse, 1);
    chk("t1_in_ready", in_ready, 1);
    feed(32, 0, -1, 0, -1, -1, acc);
    chk("t1_accepted", acc, 32);
    wait_done(ok);
    chk("t1_done_seen", ok, 1);
    chk("t1_count", mon_q.size(), 32);
    for (int i = 0; i < 32 && i < mon_q.size(); i++)
      chk($sformatf("t1_s%0d", i), mon_q[i], exp_w(i, 0));
    chk("t1_done_lat", done_cyc - last_xfer_cyc, 1);
    chk("t1_frames_done", frames_done, 2);
    step();
    chk("t1_idle_busy", busy, 0);
    chk("t1_done_pulse", done_cnt, 1);

    // Same run with sink_ready toggling every cycle
    rdy_toggle = 1'b1;
    clear_mon();
    do_start(16'd2, 1'b0, 1'b0);
    chk("t2_inverse", inverse, 0);
    feed(32, 0, -1, 0, -1, -1, acc);
    chk("t2_accepted", acc, 32);
    wait_done(ok);
    chk("t2_done_seen", ok, 1);
    chk("t2_count", mon_q.size(), 32);
    for (int i = 0; i < 32 && i < mon_q.size(); i++)
      chk($sformatf("t2_s%0d", i), mon_q[i], exp_w(i, 0));
    chk("t2_stall_stable", stall_viol, 0);
    chk("t2_frames_done", frames_done, 2);
    chk("t2_done_lat", done_cyc - last_xfer_cyc, 1);
    rdy_toggle = 1'b0;
    repeat (2) step();

    // Continuous mode, stop at sample 20 finishes frame 1
    clear_mon();
    do_start(16'd0, 1'b0, 1'b0);
    feed(40, 0, -1, 0, 20, -1, acc);
    chk("t3_accepted", acc, 32);
    chk("t3_in_ready", in_ready, 0);
    wait_done(ok);
    chk("t3_done_seen", ok, 1);
    chk("t3_count", mon_q.size(), 32);
    if (mon_q.size() == 32)
      chk("t3_last", mon_q[31], exp_w(31, 0));
    chk("t3_frames_done", frames_done, 2);
    chk("t3_idle", busy, 0);

    // Upstream gap of 5 cycles at sample 7
    clear_mon();
    do_start(16'd1, 1'b0, 1'b0);
    feed(16, 200, 7, 5, -1, -1, acc);
    chk("t4_accepted", acc, 16);
    wait_done(ok);
    chk("t4_done_seen", ok, 1);
    chk("t4_count", mon_q.size(), 16);
    for (int i = 0; i < 16 && i < mon_q.size(); i++)
      chk($sformatf("t4_s%0d", i), mon_q[i], exp_w(i, 200));
    chk("t4_frames_done", frames_done, 1);
    repeat (2) step();

    // Reset at sample 9, then a fresh run
    clear_mon();
    do_start(16'd2, 1'b1, 1'b0);
    feed(9, 0, -1, 0, -1, -1, acc);
    chk("t5_pre_accepted", acc, 9);
    rst_n = 1'b0;
    step();
    chk("t5_rst_valid", sink_valid, 0);
    chk("t5_rst_tags", {sink_sop, sink_eop, sink_real}, 0);
    chk("t5_rst_ctl", {in_ready, busy, done, inverse}, 0);
    chk("t5_rst_frames", frames_done, 0);
    rst_n = 1'b1;
    step();
    clear_mon();
    do_start(16'd1, 1'b0, 1'b0);
    feed(16, 100, -1, 0, -1, -1, acc);
    wait_done(ok);
    chk("t5_done_seen", ok, 1);
    chk("t5_count", mon_q.size(), 16);
    if (mon_q.size() == 16) begin
      chk("t5_first", mon_q[0], exp_w(0, 100));
      chk("t5_last", mon_q[15], exp_w(15, 100));
    end
    repeat (2) step();

    // Stop alone in IDLE, start+stop together, start mid-stream: all ignored where required
    clear_mon();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t6_idle_stop_busy", busy, 0);
    do_start(16'd2, 1'b0, 1'b1);
    chk("t6_busy", busy, 1);
    num_frames = 16'd1;
    feed(32, 0, -1, 0, -1, 5, acc);
    chk("t6_accepted", acc, 32);
    wait_done(ok);
    chk("t6_done_seen", ok, 1);
    chk("t6_count", mon_q.size(), 32);
    chk("t6_frames_done", frames_done, 2);
    chk("t6_done_pulses", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
